// File: rtl/sync3_bus.sv
// sync3_bus: per-bit multi-flop bus synchronizer with optional edge/change detect.
// Define SYNC3_EDGE_DET_EN to build the history register behind rise/fall/changed.
module sync3_bus #(
  parameter int WIDTH = 1,
  parameter int STAGES = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i,
  output logic [WIDTH-1:0] o,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);
  if (WIDTH < 1 || STAGES < 2 || STAGES > 8) begin : g_bad_param
    $fatal(1, "sync3_bus: WIDTH must be >= 1 and STAGES must be 2..8");
  end
  (* async_reg = "true", dont_touch = "true", preserve *) logic [STAGES-1:0][WIDTH-1:0] stage;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) stage <= {STAGES{RESET_VAL}};
    else stage <= {stage[STAGES-2:0], i};
  assign o = stage[STAGES-1];
`ifdef SYNC3_EDGE_DET_EN
  logic [WIDTH-1:0] h;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) h <= RESET_VAL;
    else h <= o;
  assign rise = o & ~h;
  assign fall = ~o & h;
  assign changed = |(o ^ h);
`else
  assign rise = '0;
  assign fall = '0;
  assign changed = 1'b0;
`endif
endmodule

// File: tb/tb_sync3_bus.sv
// tb_sync3_bus: randomized check of two sync3_bus configurations against a
// sample-history model (o is the input captured STAGES edges ago since reset).
module tb_sync3_bus;
  logic clk = 1'b0;
  logic clk_en = 1'b0;
  logic reset_n = 1'b1;
  logic [31:0] ia = '0, oa, ra, fa;
  logic [7:0] ib = '0, ob, rb, fb;
  logic ca, cb;
  logic [31:0] qa[$];
  logic [7:0] qb[$];
  logic [31:0] pa = '0;
  logic [7:0] pb = 8'hA5;
  int checks = 0;
  int errors = 0;

  always #5 if (clk_en) clk = ~clk;

  sync3_bus #(.WIDTH(32), .STAGES(3), .RESET_VAL(32'h0)) dut_a (
    .clk(clk), .reset_n(reset_n), .i(ia), .o(oa), .rise(ra), .fall(fa), .changed(ca));
  sync3_bus #(.WIDTH(8), .STAGES(2), .RESET_VAL(8'hA5)) dut_b (
    .clk(clk), .reset_n(reset_n), .i(ib), .o(ob), .rise(rb), .fall(fb), .changed(cb));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] ea;
    logic [7:0] eb;
    ea = qa.size() >= 3 ? qa[qa.size()-3] : 32'h0;
    eb = qb.size() >= 2 ? qb[qb.size()-2] : 8'hA5;
    chk({tag, ".o32"}, {32'h0, oa}, {32'h0, ea});
    chk({tag, ".o8"}, {56'h0, ob}, {56'h0, eb});
`ifdef SYNC3_EDGE_DET_EN
    chk({tag, ".rise32"}, {32'h0, ra}, {32'h0, ea & ~pa});
    chk({tag, ".fall32"}, {32'h0, fa}, {32'h0, ~ea & pa});
    chk({tag, ".chg32"}, {63'h0, ca}, {63'h0, ea != pa});
    chk({tag, ".rise8"}, {56'h0, rb}, {56'h0, eb & ~pb});
    chk({tag, ".fall8"}, {56'h0, fb}, {56'h0, ~eb & pb});
    chk({tag, ".chg8"}, {63'h0, cb}, {63'h0, eb != pb});
`else
    chk({tag, ".edges32"}, {31'h0, ca, ra | fa}, 64'h0);
    chk({tag, ".edges8"}, {55'h0, cb, rb | fb}, 64'h0);
`endif
    pa = ea;
    pb = eb;
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    if (reset_n) begin
      qa.push_back(ia);
      qb.push_back(ib);
      if (qa.size() > 8) void'(qa.pop_front());
      if (qb.size() > 8) void'(qb.pop_front());
    end
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    #1;
    qa.delete();
    qb.delete();
    pa = '0;
    pb = 8'hA5;
    check_all(tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    ia = 32'hDEADBEEF;
    ib = 8'h3C;
    #2;
    do_reset("rst_stopped");
    #5;
    reset_n = 1'b1;
    clk_en = 1'b1;
    for (int k = 0; k < 3; k++) step("rst_release");
    ia = 32'h0;
    for (int k = 0; k < 4; k++) step("settle");
    ia = 32'h12345678;
    ib = 8'h5A;
    for (int k = 0; k < 4; k++) step("latency");
    ia = 32'hFFFFFFFF;
    step("midrst_pre");
    #2;
    do_reset("midrst");
    ia = 32'h0000AAAA;
    #1;
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) step("midrst_post");
    ia = 32'h0;
    for (int k = 0; k < 3; k++) step("pulse_pre");
    ia = 32'h1;
    step("pulse2");
    step("pulse2");
    ia = 32'h0;
    for (int k = 0; k < 5; k++) step("pulse2_out");
    #2 ia = 32'h1;
    #3 ia = 32'h0;
    for (int k = 0; k < 4; k++) step("short_pulse");
    ia = 32'h3;
    for (int k = 0; k < 4; k++) step("edge_pre");
    ia = 32'h5;
    for (int k = 0; k < 4; k++) step("edge");
    for (int n = 0; n < 300; n++) begin
      ia = $urandom;
      ib = 8'($urandom);
      if ($urandom_range(0, 3) == 0) ia = ia ^ (32'h1 << $urandom_range(0, 31));
      for (int k = 0, hold = $urandom_range(1, 6); k < hold; k++) step("rand");
      if ($urandom_range(0, 19) == 0) begin
        #($urandom_range(1, 6));
        do_reset("rand_rst");
        reset_n = 1'b1;
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
